// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the five-stage pipeline hazard unit:
//   - forwarding-select encodings (FWD_RF / FWD_EX / FWD_MEM / FWD_WB)
//   - interrupt-entry FSM state enum
//   - shadow-pipe entry struct (destination info of one stage)
// Shadow entries carry an 8-bit dst field so any REG_ADDR_W up to 8 fits;
// narrower addresses are zero-extended on entry.
package pipeline_pkg;

  localparam int REG_ADDR_MAX_W = 8;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_DRAIN  = 2'd1,
    IRQ_SAVE   = 2'd2,
    IRQ_VECTOR = 2'd3
  } irq_state_e;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_MAX_W-1:0] dst;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_op;
  } shadow_entry_t;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if
// Bundles the ID-stage operand information, the EX/MEM handshakes and all
// stall/flush/forward controls exchanged with the hazard unit.
//   master : pipeline side (drives ID info, br_taken, mem_ack, irq)
//   slave  : hazard unit (drives fwd selects, stall/flush/freeze, irq pulses)
interface pipeline_hazard_unit_if #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_src1_used;
  logic                  id_src2_used;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_mem_op;
  logic                  br_taken;
  logic                  mem_ack;
  logic                  irq;
  logic [1:0]            fwd_sel1;
  logic [1:0]            fwd_sel2;
  logic                  stall_if_id;
  logic                  bubble_ex;
  logic                  flush_if_id;
  logic                  freeze;
  logic                  irq_save;
  logic                  irq_vector;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dst,
           id_reg_write, id_mem_read, id_mem_op, br_taken, mem_ack, irq,
    input  fwd_sel1, fwd_sel2, stall_if_id, bubble_ex, flush_if_id, freeze,
           irq_save, irq_vector, stall_count
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src1_used, id_src2_used, id_dst,
           id_reg_write, id_mem_read, id_mem_op, br_taken, mem_ack, irq,
    output fwd_sel1, fwd_sel2, stall_if_id, bubble_ex, flush_if_id, freeze,
           irq_save, irq_vector, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_unit_fwd_mux_sel.sv
// hazard_fwd_mux_sel
// Per-operand priority match of one source register against the EX, MEM
// and WB shadow entries. Nearest writer wins (EX, then MEM, then WB).
// Ports:
//   src, used                : source address and whether it is read
//   {ex,mem,wb}_wr/_dst      : stage holds a valid GPR writer / its dst
//   sel                      : forwarding select (FWD_* encoding)
//   hit_ex                   : source matches the EX writer
//   hit_any                  : source matches any writer in flight
module hazard_fwd_mux_sel
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W-1:0]     src,
  input  logic                      used,
  input  logic                      ex_wr,
  input  logic [REG_ADDR_MAX_W-1:0] ex_dst,
  input  logic                      mem_wr,
  input  logic [REG_ADDR_MAX_W-1:0] mem_dst,
  input  logic                      wb_wr,
  input  logic [REG_ADDR_MAX_W-1:0] wb_dst,
  output logic [1:0]                sel,
  output logic                      hit_ex,
  output logic                      hit_any
);

  logic [REG_ADDR_MAX_W-1:0] src_ext_s;
  logic                      hit_mem_s;
  logic                      hit_wb_s;

  // Match the source against each stage and pick the nearest writer
  always_comb begin
    src_ext_s = REG_ADDR_MAX_W'(src);
    hit_ex    = used & ex_wr  & (ex_dst  == src_ext_s);
    hit_mem_s = used & mem_wr & (mem_dst == src_ext_s);
    hit_wb_s  = used & wb_wr  & (wb_dst  == src_ext_s);
    hit_any   = hit_ex | hit_mem_s | hit_wb_s;
    if (hit_ex) begin
      sel = FWD_EX;
    end else if (hit_mem_s) begin
      sel = FWD_MEM;
    end else if (hit_wb_s) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
// Hazard, forwarding and sequencing controller for the IF/ID/EX/MEM/WB
// pipeline. Keeps a shadow copy of EX/MEM/WB destination info and derives
// forwarding selects, load-use stalls, branch flushes, memory freezes and
// the drain -> save -> vector interrupt entry sequence.
// Ports:
//   clk      : pipeline clock
//   reset_n  : synchronous active-low reset
//   hz       : pipeline_hazard_unit_if.slave (ID info, handshakes, controls)
// Configuration macro HAZARD_FWD_EN:
//   defined   -> operand forwarding plus one-cycle load-use stall
//   undefined -> fwd selects tied to FWD_RF; any RAW match stalls until the
//                writer retires
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input logic                   clk,
  input logic                   reset_n,
  pipeline_hazard_unit_if.slave hz
);

  shadow_entry_t    ex_r, mem_r, wb_r, id_entry_s;
  irq_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] stall_count_r;

  logic [1:0] sel1_raw_s, sel2_raw_s;
  logic       hit_ex1_s, hit_ex2_s, hit_any1_s, hit_any2_s;
  logic       freeze_s, flush_s, hazard_s, pipe_empty_s;
  logic [1:0] fwd1_s, fwd2_s;
  logic       stall_s, bubble_s, flush_out_s, irq_save_s, irq_vector_s;
  logic       unused_s;

  hazard_fwd_mux_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel1 (
    .src(hz.id_src1), .used(hz.id_src1_used),
    .ex_wr(ex_r.valid & ex_r.reg_write),   .ex_dst(ex_r.dst),
    .mem_wr(mem_r.valid & mem_r.reg_write), .mem_dst(mem_r.dst),
    .wb_wr(wb_r.valid & wb_r.reg_write),   .wb_dst(wb_r.dst),
    .sel(sel1_raw_s), .hit_ex(hit_ex1_s), .hit_any(hit_any1_s)
  );

  hazard_fwd_mux_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel2 (
    .src(hz.id_src2), .used(hz.id_src2_used),
    .ex_wr(ex_r.valid & ex_r.reg_write),   .ex_dst(ex_r.dst),
    .mem_wr(mem_r.valid & mem_r.reg_write), .mem_dst(mem_r.dst),
    .wb_wr(wb_r.valid & wb_r.reg_write),   .wb_dst(wb_r.dst),
    .sel(sel2_raw_s), .hit_ex(hit_ex2_s), .hit_any(hit_any2_s)
  );

  // Raw hazard conditions from the shadow pipe and handshakes
  always_comb begin
    freeze_s     = mem_r.valid & mem_r.mem_op & ~hz.mem_ack;
    flush_s      = hz.br_taken & ex_r.valid;
    pipe_empty_s = ~(ex_r.valid | mem_r.valid | wb_r.valid);
`ifdef HAZARD_FWD_EN
    // Only a load in EX cannot be forwarded; MEM forward covers next cycle
    hazard_s = hz.id_valid & ex_r.mem_read & (hit_ex1_s | hit_ex2_s);
`else
    hazard_s = hz.id_valid & (hit_any1_s | hit_any2_s);
`endif
  end

`ifdef HAZARD_FWD_EN
  assign unused_s = ^{hit_any1_s, hit_any2_s, ex_r.mem_op, mem_r.mem_read,
                      wb_r.mem_read, wb_r.mem_op};
`else
  assign unused_s = ^{sel1_raw_s, sel2_raw_s, hit_ex1_s, hit_ex2_s,
                      ex_r.mem_read, ex_r.mem_op, mem_r.mem_read,
                      wb_r.mem_read, wb_r.mem_op};
`endif

  // FSM output decode with priority freeze > flush > drain/stall
  always_comb begin
    fwd1_s       = FWD_RF;
    fwd2_s       = FWD_RF;
    stall_s      = 1'b0;
    bubble_s     = 1'b0;
    flush_out_s  = 1'b0;
    irq_save_s   = 1'b0;
    irq_vector_s = 1'b0;
    if (freeze_s) begin
      fwd1_s = FWD_RF;
    end else begin
`ifdef HAZARD_FWD_EN
      fwd1_s = sel1_raw_s;
      fwd2_s = sel2_raw_s;
`else
      fwd1_s = FWD_RF;
      fwd2_s = FWD_RF;
`endif
      if (flush_s) begin
        flush_out_s = 1'b1;
        bubble_s    = 1'b1;
      end else if ((state_r == IRQ_DRAIN) || hazard_s) begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
      end else begin
        stall_s = 1'b0;
      end
      irq_save_s   = (state_r == IRQ_SAVE);
      irq_vector_s = (state_r == IRQ_VECTOR);
    end
  end

  // Interrupt FSM next-state; every state holds while frozen
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IRQ_IDLE: begin
        if (hz.irq && !freeze_s) state_nxt_s = IRQ_DRAIN;
        else                     state_nxt_s = IRQ_IDLE;
      end
      IRQ_DRAIN: begin
        if (!freeze_s && pipe_empty_s) state_nxt_s = IRQ_SAVE;
        else                           state_nxt_s = IRQ_DRAIN;
      end
      IRQ_SAVE: begin
        if (freeze_s) state_nxt_s = IRQ_SAVE;
        else          state_nxt_s = IRQ_VECTOR;
      end
      IRQ_VECTOR: begin
        if (freeze_s) state_nxt_s = IRQ_VECTOR;
        else          state_nxt_s = IRQ_IDLE;
      end
      default: state_nxt_s = IRQ_IDLE;
    endcase
  end

  // Next EX entry from the ID inputs; a bubble or flush inserts a NOP
  always_comb begin
    id_entry_s.valid     = hz.id_valid & ~bubble_s;
    id_entry_s.dst       = REG_ADDR_MAX_W'(hz.id_dst);
    id_entry_s.reg_write = hz.id_reg_write;
    id_entry_s.mem_read  = hz.id_mem_read;
    id_entry_s.mem_op    = hz.id_mem_op;
  end

  // Interrupt FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) state_r <= IRQ_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Shadow pipe advances every unfrozen cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else if (!freeze_s) begin
      ex_r  <= id_entry_s;
      mem_r <= ex_r;
      wb_r  <= mem_r;
    end else begin
      ex_r  <= ex_r;
      mem_r <= mem_r;
      wb_r  <= wb_r;
    end
  end

  // Saturating count of stalled or frozen cycles
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if ((stall_s || freeze_s) && !(&stall_count_r)) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign hz.fwd_sel1    = fwd1_s;
  assign hz.fwd_sel2    = fwd2_s;
  assign hz.stall_if_id = stall_s;
  assign hz.bubble_ex   = bubble_s;
  assign hz.flush_if_id = flush_out_s;
  assign hz.freeze      = freeze_s;
  assign hz.irq_save    = irq_save_s;
  assign hz.irq_vector  = irq_vector_s;
  assign hz.stall_count = stall_count_r;

endmodule
